// File: rtl/stereo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stereo_pkg
// Description : Shared types and word-packing offsets for the stereo column
//               feed path.
// Revision    : 1.0 - initial release
// ============================================================================
package stereo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } feed_state_t;

    // Bit positions counted down from the MSB of the {tuser, tlast, tdata} word.
    localparam int c_tuser_from_msb = 0;
    localparam int c_tlast_from_msb = 1;

endpackage
`default_nettype wire

// File: rtl/column_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : column_feed_ctrl
// Description : Accepts an AXI-Stream pixel frame, tags each beat with its
//               column/row and appends blank flush lines for the delay chain.
// Revision    : 1.0 - initial release
// ============================================================================
module column_feed_ctrl
    import stereo_pkg::*;
#(
    parameter int PIX_WIDTH   = 8,
    parameter int PPC         = 4,
    parameter int LINE_WORDS  = 960,
    parameter int FRAME_LINES = 1080,
    parameter int FLUSH_LINES = 2,
    localparam int DATA_WIDTH = PPC * PIX_WIDTH + 2,
    localparam int COL_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
    localparam int ROW_W      = (FRAME_LINES + FLUSH_LINES > 1) ?
                                $clog2(FRAME_LINES + FLUSH_LINES) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PPC*PIX_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     m_ready,
    output logic                     ce,
    output logic [DATA_WIDTH-1:0]    din,
    output logic [COL_W-1:0]         col,
    output logic [ROW_W-1:0]         row,
    output logic                     flushing,
    output logic                     err_line,
    output logic                     err_sof
);

    localparam logic [COL_W-1:0] c_col_last        = COL_W'(LINE_WORDS - 1);
    localparam logic [ROW_W-1:0] c_row_last_frame  = ROW_W'(FRAME_LINES - 1);
    localparam logic [ROW_W-1:0] c_row_last_flush  = ROW_W'(FRAME_LINES + FLUSH_LINES - 1);
    localparam int               c_tuser_bit       = DATA_WIDTH - 1 - c_tuser_from_msb;
    localparam int               c_tlast_bit       = DATA_WIDTH - 1 - c_tlast_from_msb;
    localparam int               c_pix_bits        = PPC * PIX_WIDTH;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    feed_state_t           r_state;
    logic [COL_W-1:0]      r_col_cnt;
    logic [ROW_W-1:0]      r_row_cnt;

    logic                  w_accept;
    logic                  w_restart;
    logic                  w_emit_data;
    logic                  w_emit_flush;
    logic [COL_W-1:0]      w_pos_col;
    logic [ROW_W-1:0]      w_pos_row;
    logic                  w_col_wrap;
    logic [COL_W-1:0]      w_col_next;
    logic [ROW_W-1:0]      w_row_next;
    logic                  w_frame_end;
    logic                  w_flush_end;
    logic [DATA_WIDTH-1:0] w_data_word;

    // Assert asynchronously, release two clocks after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n       = r_rst_sync[1];
    assign s_axis_tready = w_rst_n & m_ready & (r_state != ST_FLUSH);

    always_comb begin
        w_accept     = s_axis_tvalid & s_axis_tready;
        w_restart    = w_accept & s_axis_tuser;
        w_emit_data  = w_accept & ((r_state == ST_ACTIVE) | s_axis_tuser);
        w_emit_flush = (r_state == ST_FLUSH) & m_ready;
        // A start-of-frame beat always lands at the origin, whatever the counters say.
        w_pos_col    = w_restart ? '0 : r_col_cnt;
        w_pos_row    = w_restart ? '0 : r_row_cnt;
        w_col_wrap   = (w_pos_col == c_col_last);
        w_col_next   = w_col_wrap ? '0 : w_pos_col + COL_W'(1);
        w_row_next   = w_col_wrap ? w_pos_row + ROW_W'(1) : w_pos_row;
        w_frame_end  = w_col_wrap & (w_pos_row == c_row_last_frame);
        w_flush_end  = w_col_wrap & (w_pos_row == c_row_last_flush);
        w_data_word  = '0;
        if (w_emit_data) begin
            w_data_word[c_tuser_bit]    = s_axis_tuser;
            w_data_word[c_tlast_bit]    = s_axis_tlast;
            w_data_word[c_pix_bits-1:0] = s_axis_tdata;
        end else begin
            w_data_word[c_tlast_bit]    = w_col_wrap;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            ce        <= 1'b0;
            din       <= '0;
            col       <= '0;
            row       <= '0;
            flushing  <= 1'b0;
            err_line  <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            ce <= w_emit_data | w_emit_flush;
            if (w_emit_data || w_emit_flush) begin
                din      <= w_data_word;
                col      <= w_pos_col;
                row      <= w_pos_row;
                flushing <= w_emit_flush;
            end
            if (w_emit_data) begin
                // Counters follow the column wrap; a misplaced tlast is only flagged.
                if (s_axis_tlast != w_col_wrap) begin
                    err_line <= 1'b1;
                end
                if (w_restart && (r_state == ST_ACTIVE)) begin
                    err_sof <= 1'b1;
                end
                if (w_frame_end) begin
                    r_state   <= (FLUSH_LINES > 0) ? ST_FLUSH : ST_IDLE;
                    r_col_cnt <= '0;
                    r_row_cnt <= (FLUSH_LINES > 0) ? w_row_next : '0;
                end else begin
                    r_state   <= ST_ACTIVE;
                    r_col_cnt <= w_col_next;
                    r_row_cnt <= w_row_next;
                end
            end else if (w_emit_flush) begin
                if (w_flush_end) begin
                    r_state   <= ST_IDLE;
                    r_col_cnt <= '0;
                    r_row_cnt <= '0;
                end else begin
                    r_col_cnt <= w_col_next;
                    r_row_cnt <= w_row_next;
                end
            end
        end
    end

endmodule
`default_nettype wire
